// File: rtl/ir_pulse_conditioner.sv
// IR detector conditioner: 2-flop synchronizer, symmetric debounce FSM, glitch counter.
// Optional pulse-width measurement is built when the macro IR_PULSE_WIDTH_EN is defined.
module ir_pulse_conditioner #(
   parameter int unsigned FILT_CYC = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ir_raw,
   input  logic       glitch_clr,
   output logic       detect_pin,
   output logic       pulse_stb,
   output logic [7:0] glitch_cnt
`ifdef IR_PULSE_WIDTH_EN
   ,
   output logic [9:0] pulse_width,
   output logic       width_vld
`endif
);

   localparam logic [1:0] S_LOW      = 2'd0;
   localparam logic [1:0] S_RISE_CHK = 2'd1;
   localparam logic [1:0] S_HIGH     = 2'd2;
   localparam logic [1:0] S_FALL_CHK = 2'd3;
   localparam logic [7:0] STAB_LAST  = 8'(FILT_CYC - 1);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      return (v == 10'h3FF) ? v : v + 10'd1;
   endfunction

   logic       r_q1;
   logic       r_q2;
   logic [1:0] r_state;
   logic [7:0] r_stab;
   logic [1:0] w_state_nxt;
   logic [7:0] w_stab_nxt;
   logic       w_glitch;
   logic       w_rise;
   logic       w_fall;

   // The first q2 sample of a new level counts as stab 0, so FILT_CYC+1 samples qualify a change.
   always_comb begin
      w_state_nxt = r_state;
      w_stab_nxt  = r_stab;
      w_glitch    = 1'b0;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      case (r_state)
         S_LOW: begin
            if (r_q2) begin
               w_state_nxt = S_RISE_CHK;
               w_stab_nxt  = 8'd0;
            end
         end
         S_RISE_CHK: begin
            if (!r_q2) begin
               w_state_nxt = S_LOW;
               w_glitch    = 1'b1;
            end else if (r_stab == STAB_LAST) begin
               w_state_nxt = S_HIGH;
               w_rise      = 1'b1;
            end else begin
               w_stab_nxt  = r_stab + 8'd1;
            end
         end
         S_HIGH: begin
            if (!r_q2) begin
               w_state_nxt = S_FALL_CHK;
               w_stab_nxt  = 8'd0;
            end
         end
         S_FALL_CHK: begin
            if (r_q2) begin
               w_state_nxt = S_HIGH;
               w_glitch    = 1'b1;
            end else if (r_stab == STAB_LAST) begin
               w_state_nxt = S_LOW;
               w_fall      = 1'b1;
            end else begin
               w_stab_nxt  = r_stab + 8'd1;
            end
         end
         default: w_state_nxt = S_LOW;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q1       <= 1'b0;
         r_q2       <= 1'b0;
         r_state    <= S_LOW;
         r_stab     <= 8'd0;
         detect_pin <= 1'b0;
         pulse_stb  <= 1'b0;
         glitch_cnt <= 8'd0;
      end else begin
         r_q1       <= ir_raw;
         r_q2       <= r_q1;
         r_state    <= w_state_nxt;
         r_stab     <= w_stab_nxt;
         detect_pin <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_FALL_CHK);
         pulse_stb  <= w_rise;
         if (glitch_clr)
            glitch_cnt <= 8'd0;
         else if (w_glitch)
            glitch_cnt <= sat_inc8(glitch_cnt);
      end
   end

`ifdef IR_PULSE_WIDTH_EN
   logic [9:0] r_acc;

   // Accumulator holds (high cycles - 1) while the pulse runs; the exit edge adds the final cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc       <= 10'd0;
         pulse_width <= 10'd0;
         width_vld   <= 1'b0;
      end else begin
         width_vld <= w_fall;
         if (w_rise)
            r_acc <= 10'd0;
         else if ((r_state == S_HIGH) || (r_state == S_FALL_CHK))
            r_acc <= sat_inc10(r_acc);
         if (w_fall)
            pulse_width <= sat_inc10(r_acc);
      end
   end
`endif

endmodule

// File: tb/tb_ir_pulse_conditioner.sv
// Randomized and directed bench for ir_pulse_conditioner against a run-length reference model.
module tb_ir_pulse_conditioner;

   localparam int unsigned FILT = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ir_raw;
   logic       glitch_clr;
   logic       detect_pin;
   logic       pulse_stb;
   logic [7:0] glitch_cnt;
`ifdef IR_PULSE_WIDTH_EN
   logic [9:0] pulse_width;
   logic       width_vld;
`endif

   always #5 clk = ~clk;

   ir_pulse_conditioner #(.FILT_CYC(FILT)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ir_raw     (ir_raw),
      .glitch_clr (glitch_clr),
      .detect_pin (detect_pin),
      .pulse_stb  (pulse_stb),
      .glitch_cnt (glitch_cnt)
`ifdef IR_PULSE_WIDTH_EN
      ,
      .pulse_width(pulse_width),
      .width_vld  (width_vld)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: input pipeline history plus a run length of samples disagreeing with the output.
   bit m_q1, m_q2, m_det, m_stb, m_vld;
   int m_run, m_glitch, m_width, m_rise_cyc, cyc;

   task automatic step(input logic ir, input logic rn, input logic clr);
      bit s, gl;
      @(negedge clk);
      ir_raw     = ir;
      rst_n      = rn;
      glitch_clr = clr;
      @(posedge clk);
      cyc++;
      m_stb = 1'b0;
      m_vld = 1'b0;
      if (!rn) begin
         m_q1 = 0; m_q2 = 0; m_det = 0; m_run = 0; m_glitch = 0; m_width = 0;
      end else begin
         s    = m_q2;
         m_q2 = m_q1;
         m_q1 = ir;
         gl   = 1'b0;
         if (s != m_det) begin
            m_run++;
            if (m_run == int'(FILT) + 1) begin
               m_det = s;
               m_run = 0;
               if (s) begin
                  m_stb      = 1'b1;
                  m_rise_cyc = cyc;
               end else begin
                  m_vld   = 1'b1;
                  m_width = (cyc - m_rise_cyc > 1023) ? 1023 : cyc - m_rise_cyc;
               end
            end
         end else begin
            if (m_run > 0) gl = 1'b1;
            m_run = 0;
         end
         if (clr) m_glitch = 0;
         else if (gl && m_glitch < 255) m_glitch++;
      end
      #1;
      check("detect_pin", 32'(detect_pin), 32'(m_det));
      check("pulse_stb", 32'(pulse_stb), 32'(m_stb));
      check("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
`ifdef IR_PULSE_WIDTH_EN
      check("width_vld", 32'(width_vld), 32'(m_vld));
      check("pulse_width", 32'(pulse_width), 32'(m_width));
`endif
   endtask

   task automatic hold(input logic ir, input int n, input logic clr);
      for (int i = 0; i < n; i++) step(ir, 1'b1, clr);
   endtask

   int lat;
   int vld_seen;
   logic lvl;

   initial begin
      m_q1 = 0; m_q2 = 0; m_det = 0; m_stb = 0; m_vld = 0;
      m_run = 0; m_glitch = 0; m_width = 0; m_rise_cyc = 0; cyc = 0;
      ir_raw = 1'b0; rst_n = 1'b0; glitch_clr = 1'b0;

      // reset state
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("rst_detect", 32'(detect_pin), 32'd0);
      check("rst_glitch", 32'(glitch_cnt), 32'd0);
      hold(1'b0, 10, 1'b0);

      // 20-cycle pulse: rise latency FILT+2, width 20
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (lat < 0 && detect_pin) lat = i;
      end
      check("rise_latency", 32'(lat), 32'(FILT + 2));
      lat = -1;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (lat < 0 && !detect_pin) lat = i;
      end
      check("fall_latency", 32'(lat), 32'(FILT + 2));
`ifdef IR_PULSE_WIDTH_EN
      check("width_20", 32'(pulse_width), 32'd20);
`endif

      // 3-cycle glitch, then 4-cycle dip inside a long pulse
      hold(1'b1, 3, 1'b0);
      hold(1'b0, 20, 1'b0);
      check("glitch_short", 32'(glitch_cnt), 32'd1);
      hold(1'b1, 40, 1'b0);
      hold(1'b0, 4, 1'b0);
      hold(1'b1, 20, 1'b0);
      check("dip_keeps_high", 32'(detect_pin), 32'd1);
      check("glitch_dip", 32'(glitch_cnt), 32'd2);
      hold(1'b0, 30, 1'b0);

      // saturation, clear, clear coincident with a glitch
      for (int g = 0; g < 300; g++) begin
         hold(1'b1, 2, 1'b0);
         hold(1'b0, 2, 1'b0);
      end
      hold(1'b0, 6, 1'b0);
      check("glitch_sat", 32'(glitch_cnt), 32'd255);
      step(1'b0, 1'b1, 1'b1);
      check("glitch_clr", 32'(glitch_cnt), 32'd0);
      hold(1'b1, 2, 1'b0);
      hold(1'b0, 8, 1'b0);
      hold(1'b1, 2, 1'b1);
      hold(1'b0, 8, 1'b1);
      check("clr_wins", 32'(glitch_cnt), 32'd0);
      hold(1'b0, 5, 1'b0);

      // 2000-cycle pulse saturates the width
      vld_seen = 0;
      for (int i = 0; i < 2000; i++) step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b0);
`ifdef IR_PULSE_WIDTH_EN
         if (width_vld) vld_seen++;
`endif
      end
`ifdef IR_PULSE_WIDTH_EN
      check("width_sat", 32'(pulse_width), 32'd1023);
      check("width_vld_once", 32'(vld_seen), 32'd1);
`endif

      // reset while high, input held high: full re-qualification
      hold(1'b1, 15, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("rst_mid_detect", 32'(detect_pin), 32'd0);
      lat = -1;
      for (int i = 0; i < 15; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (lat < 0 && detect_pin) lat = i;
      end
      check("rst_requal", 32'(lat), 32'(FILT + 2));
      hold(1'b0, 15, 1'b0);

      // randomized runs with occasional clear and reset
      lvl = 1'b0;
      for (int r = 0; r < 300; r++) begin
         int len;
         lvl = ~lvl;
         len = int'($urandom_range(1, 10));
         for (int i = 0; i < len; i++)
            step(lvl, ($urandom_range(0, 499) != 0), ($urandom_range(0, 19) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
